// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM encodings, NOP word, IF/ID write-control encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,  // request outstanding at imem_addr_o == pc
        ST_HAVE = 2'd1,  // instruction parked in the 1-entry buffer, waiting for the hazard to clear
        ST_DROP = 2'd2   // redirected while a request was in flight; response will be thrown away
    } fetch_state_e;

    localparam logic [31:0] NOP             = 32'h0000_0000;
    // Same encodings the hazard unit drives; only bit1 carries meaning.
    localparam logic [1:0]  IF_ID_WR_UPDATE = 2'b10;
    localparam logic [1:0]  IF_ID_WR_HOLD   = 2'b00;

    // Branch targets arrive byte-addressed; fetch is always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: {pc+4, instr, valid} with hold enable and flush-to-bubble.
// Latency: 1 cycle from load/bubble request to outputs.
// Backpressure: load_i=0 and bubble_i=0 holds every field; bubble_i wins over load_i.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc4_q;
    logic [31:0] instr_q;
    logic        valid_q;

    // Bubble inserts a NOP marked invalid; load captures a real instruction; otherwise hold.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc4_q   <= 32'h0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            pc4_q   <= pc4_i;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc4_q   <= pc4_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, single-outstanding req/ack to imem, feeds IF/ID register.
// Latency: ack in cycle N -> instruction visible on IF/ID after edge N (1 IPC with zero-wait imem).
// Backpressure: hazard stall parks the fetched word in a 1-entry buffer and drops imem_req_o.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pc_write_i,
    input  logic [1:0]       if_id_write_i,
    input  logic             flush_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      if_id_pc4_o,
    output logic [31:0]      if_id_instr_o,
    output logic             if_id_valid_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    fetch_state_e     state_q;
    logic [31:0]      pc_q;
    logic [31:0]      addr_q;
    logic             req_q;
    logic [31:0]      buf_q;
    logic [CNT_W-1:0] cnt_q;

    logic        ifid_wr_en;
    logic        ack_hit;
    logic        avail;
    logic        adv;
    logic        adv_eff;
    logic        ifid_load;
    logic        ifid_bubble;
    logic [31:0] pc4;
    logic [31:0] cur_instr;

    // Handshake qualifiers and IF/ID control. A flush alone does not advance the PC, so an
    // arriving word is parked rather than lost.
    always_comb begin
        ifid_wr_en  = |(if_id_write_i & IF_ID_WR_UPDATE);
        ack_hit     = req_q & imem_ack_i;
        avail       = ((state_q == ST_REQ) & ack_hit) | (state_q == ST_HAVE);
        adv         = ifid_wr_en & pc_write_i;
        adv_eff     = adv & ~flush_i;
        pc4         = pc_q + 32'd4;
        cur_instr   = (state_q == ST_HAVE) ? buf_q : imem_rdata_i;
        ifid_load   = ~flush_i & ~redirect_i & avail & adv;
        ifid_bubble = flush_i | (~redirect_i & ~avail & ifid_wr_en);
    end

    // Fetch FSM with registered request/address, PC, fetch buffer and saturating bubble counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            buf_q   <= NOP;
            cnt_q   <= '0;
        end else begin
            if (ifid_bubble && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (redirect_i) begin
                pc_q  <= word_align(redirect_pc_i);
                req_q <= 1'b1;
                if (state_q != ST_HAVE && req_q && !imem_ack_i) begin
                    // In-flight request must keep its address until acked.
                    state_q <= ST_DROP;
                end else begin
                    state_q <= ST_REQ;
                    addr_q  <= word_align(redirect_pc_i);
                end
            end else begin
                case (state_q)
                    ST_REQ: begin
                        if (!req_q) begin
                            req_q <= 1'b1;
                        end else if (imem_ack_i) begin
                            if (adv_eff) begin
                                pc_q   <= pc4;
                                addr_q <= pc4;
                            end else begin
                                buf_q   <= imem_rdata_i;
                                state_q <= ST_HAVE;
                                req_q   <= 1'b0;
                            end
                        end
                    end
                    ST_HAVE: begin
                        if (adv_eff) begin
                            pc_q    <= pc4;
                            addr_q  <= pc4;
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (imem_ack_i) begin
                            state_q <= ST_REQ;
                            addr_q  <= pc_q;
                        end
                    end
                    default: begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                endcase
            end
        end
    end

    fetch_stage_if_id_reg u_if_id (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .pc4_i    (pc4),
        .instr_i  (cur_instr),
        .pc4_o    (if_id_pc4_o),
        .instr_o  (if_id_instr_o),
        .valid_o  (if_id_valid_o)
    );

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign pc_o         = pc_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scripted per-cycle stimulus, scoreboard of expected IF/ID loads.
// Latency: n/a.
// Backpressure: imem acks and hazard controls are driven directly by each scenario task.
module tb_fetch_stage;

    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             pc_write_i = 1'b0;
    logic [1:0]       if_id_write_i = 2'b00;
    logic             flush_i = 1'b0;
    logic             redirect_i = 1'b0;
    logic [31:0]      redirect_pc_i = 32'h0;
    logic             imem_req_o;
    logic [31:0]      imem_addr_o;
    logic             imem_ack_i = 1'b0;
    logic [31:0]      imem_rdata_i;
    logic [31:0]      pc_o;
    logic [31:0]      if_id_pc4_o;
    logic [31:0]      if_id_instr_o;
    logic             if_id_valid_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0]      sb_q[$];
    logic [31:0]      exp_pc;
    logic [CNT_W-1:0] exp_cnt;
    logic             prev_valid;
    logic [31:0]      prev_pc4;
    logic [31:0]      prev_instr;

    fetch_stage #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_write_i    (pc_write_i),
        .if_id_write_i (if_id_write_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_valid_o (if_id_valid_o),
        .bubble_cnt_o  (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory content: unique, never zero, derived from the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'h8C, a[25:2]};
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    // One clock of stimulus; expectations queued before the edge, checked #1 after it.
    task automatic step(input logic pcw, input logic [1:0] ifw, input logic fl, input logic rd,
                        input logic [31:0] rpc, input logic ack, input logic exp_ld,
                        input logic exp_bub);
        logic        new_ld;
        logic [63:0] exp_e;
        pc_write_i    = pcw;
        if_id_write_i = ifw;
        flush_i       = fl;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_ack_i    = ack;
        if (exp_ld) begin
            sb_q.push_back({exp_pc + 32'd4, mem_word(exp_pc)});
            exp_pc = exp_pc + 32'd4;
        end
        if (rd) exp_pc = rpc & 32'hFFFF_FFFC;
        if (exp_bub && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk_i);
        #1;
        new_ld = if_id_valid_o && (!prev_valid || if_id_pc4_o !== prev_pc4 ||
                                   if_id_instr_o !== prev_instr);
        vectors++;
        if (new_ld !== exp_ld) begin
            miscompares++;
            $display("FAIL ifid_load_event: got %0b want %0b (pc4=%h instr=%h)",
                     new_ld, exp_ld, if_id_pc4_o, if_id_instr_o);
        end
        if (new_ld && exp_ld) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL ifid_scoreboard_empty: got load %h/%h want none",
                         if_id_pc4_o, if_id_instr_o);
            end else begin
                exp_e = sb_q.pop_front();
                if ({if_id_pc4_o, if_id_instr_o} !== exp_e) begin
                    miscompares++;
                    $display("FAIL ifid_data: got %h/%h want %h/%h",
                             if_id_pc4_o, if_id_instr_o, exp_e[63:32], exp_e[31:0]);
                end
            end
        end
        if (exp_bub) begin
            vectors++;
            if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin
                miscompares++;
                $display("FAIL ifid_bubble: got valid=%0b instr=%h want 0/00000000",
                         if_id_valid_o, if_id_instr_o);
            end
        end
        vectors++;
        if (pc_o !== exp_pc) begin
            miscompares++;
            $display("FAIL pc: got %h want %h", pc_o, exp_pc);
        end
        vectors++;
        if (bubble_cnt_o !== exp_cnt) begin
            miscompares++;
            $display("FAIL bubble_cnt: got %0d want %0d", bubble_cnt_o, exp_cnt);
        end
        prev_valid = if_id_valid_o;
        prev_pc4   = if_id_pc4_o;
        prev_instr = if_id_instr_o;
    endtask

    // Normal advancing controls, only ack varies.
    task automatic go(input logic ack, input logic exp_ld, input logic exp_bub);
        step(1'b1, 2'b10, 1'b0, 1'b0, 32'h0, ack, exp_ld, exp_bub);
    endtask

    task automatic do_reset();
        pc_write_i = 1'b0; if_id_write_i = 2'b00; flush_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_ack_i = 1'b0;
        rst_i = 1'b0;
        #2;
        vectors++;
        if (pc_o !== RESET_PC || if_id_valid_o !== 1'b0 || bubble_cnt_o !== '0 ||
            imem_req_o !== 1'b0 || if_id_instr_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: got pc=%h valid=%0b cnt=%0d req=%0b instr=%h pc4=%h want %h/0/0/0/0/0",
                     pc_o, if_id_valid_o, bubble_cnt_o, imem_req_o, if_id_instr_o, if_id_pc4_o, RESET_PC);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        exp_pc = RESET_PC; exp_cnt = '0;
        prev_valid = 1'b0; prev_pc4 = 32'h0; prev_instr = 32'h0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        go(1'b0, 1'b0, 1'b1);
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
            miscompares++;
            $display("FAIL req_after_release: got req=%0b addr=%h want 1/%h", imem_req_o, imem_addr_o, RESET_PC);
        end
    endtask

    task automatic test_stream();
        repeat (6) go(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_slow_ack();
        logic [CNT_W-1:0] c0;
        c0 = bubble_cnt_o;
        for (int i = 0; i < 3; i++) begin
            go(1'b0, 1'b0, 1'b1);
            go(1'b0, 1'b0, 1'b1);
            go(1'b1, 1'b1, 1'b0);
        end
        vectors++;
        if (bubble_cnt_o !== c0 + CNT_W'(6)) begin
            miscompares++;
            $display("FAIL slow_ack_bubbles: got %0d want %0d", bubble_cnt_o, c0 + CNT_W'(6));
        end
    endtask

    task automatic test_load_use();
        do_reset();
        go(1'b0, 1'b0, 1'b1);
        go(1'b1, 1'b1, 1'b0);
        go(1'b1, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (imem_req_o !== 1'b0 || pc_o !== 32'h8) begin
            miscompares++;
            $display("FAIL load_use_have: got req=%0b pc=%h want 0/00000008", imem_req_o, pc_o);
        end
        step(1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin
            miscompares++;
            $display("FAIL load_use_no_refetch: got req=%0b addr=%h want 1/0000000c", imem_req_o, imem_addr_o);
        end
        go(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_redirect_drop();
        logic [31:0] old_addr;
        old_addr = exp_pc;
        step(1'b1, 2'b10, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== old_addr) begin
            miscompares++;
            $display("FAIL drop_addr_hold: got req=%0b addr=%h want 1/%h", imem_req_o, imem_addr_o, old_addr);
        end
        go(1'b0, 1'b0, 1'b1);
        vectors++;
        if (imem_addr_o !== old_addr) begin
            miscompares++;
            $display("FAIL drop_addr_hold2: got %h want %h", imem_addr_o, old_addr);
        end
        go(1'b1, 1'b0, 1'b1);
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            miscompares++;
            $display("FAIL drop_next_req: got req=%0b addr=%h want 1/00000040", imem_req_o, imem_addr_o);
        end
        go(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_align_wrap();
        step(1'b1, 2'b10, 1'b1, 1'b1, 32'h43, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (imem_addr_o !== 32'h40) begin
            miscompares++;
            $display("FAIL redirect_align: got %h want 00000040", imem_addr_o);
        end
        step(1'b1, 2'b10, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
        go(1'b1, 1'b1, 1'b0);
        vectors++;
        if (if_id_pc4_o !== 32'h0 || pc_o !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: got pc4=%h pc=%h want 0/0", if_id_pc4_o, pc_o);
        end
        go(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_drop_saturate();
        step(1'b1, 2'b10, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 20; i++) go(1'b0, 1'b0, 1'b1);
        vectors++;
        if (bubble_cnt_o !== CNT_MAX) begin
            miscompares++;
            $display("FAIL bubble_saturate: got %0d want %0d", bubble_cnt_o, CNT_MAX);
        end
        go(1'b1, 1'b1, 1'b0);
        go(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        exp_pc = RESET_PC; exp_cnt = '0;
        prev_valid = 1'b0; prev_pc4 = 32'h0; prev_instr = 32'h0;
        #3;
        test_reset();
        test_stream();
        test_slow_ack();
        test_load_use();
        test_redirect_drop();
        test_align_wrap();
        test_reset_drop_saturate();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
